// File: rtl/ahb3lite_sram_ws.sv
// ahb3lite_sram_ws: AHB3-Lite slave SRAM with configurable wait states,
// a two-cycle ERROR response for out-of-range, misaligned and oversize
// transfers, and write-to-read forwarding for back-to-back accesses to the
// same word. The storage array is inferred inside the block.
//
// Optional build macro AHB3LITE_SRAM_PRIV_EN: when defined, user-mode
// transfers (HPROT[1]=0) are refused with an ERROR response. When it is
// undefined, HPROT is ignored.
module ahb3lite_sram_ws #(
  parameter int MEM_BYTES   = 1024,
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BE_W  = HDATA_SIZE / 8;
  localparam int WSH   = $clog2(BE_W);
  localparam int OFF_W = (BE_W > 1) ? WSH : 1;
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IDX_W = (AW > WSH) ? (AW - WSH) : 1;
  localparam int WORDS = MEM_BYTES / BE_W;

  localparam logic [3:0]          WS_INIT   = 4'(WAIT_STATES);
  localparam logic [HADDR_SIZE:0] MEM_LIMIT = (HADDR_SIZE+1)'(MEM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte lanes touched by a transfer of 2**size bytes starting at lane off.
  function automatic logic [BE_W-1:0] byte_en(input logic [2:0]       size,
                                              input logic [OFF_W-1:0] off);
    logic [BE_W-1:0] be;
    int              nbytes;
    int              lo;
    nbytes = 1 << size;
    lo     = int'(off);
    for (int b = 0; b < BE_W; b++) begin
      be[b] = (b >= lo) && (b < lo + nbytes);
    end
    return be;
  endfunction

  // Address/size legality independent of protection attributes.
  function automatic logic is_illegal(input logic [HADDR_SIZE-1:0] addr,
                                      input logic [2:0]            size);
    logic       out_of_range;
    logic       misaligned;
    logic       oversize;
    logic [7:0] amask;
    out_of_range = {1'b0, addr} >= MEM_LIMIT;
    amask        = 8'((32'd1 << size) - 32'd1);
    misaligned   = |(addr[7:0] & amask);
    oversize     = (32'd8 << size) > 32'(HDATA_SIZE);
    return out_of_range | misaligned | oversize;
  endfunction

  // Replace the enabled byte lanes of base with those of upd.
  function automatic logic [HDATA_SIZE-1:0] merge_bytes(
    input logic [HDATA_SIZE-1:0] base,
    input logic [HDATA_SIZE-1:0] upd,
    input logic [BE_W-1:0]       be
  );
    logic [HDATA_SIZE-1:0] res;
    for (int b = 0; b < BE_W; b++) begin
      res[8*b +: 8] = be[b] ? upd[8*b +: 8] : base[8*b +: 8];
    end
    return res;
  endfunction

  // FSM and registered bus responses
  state_e     state_q;
  logic [3:0] cnt_q;
  logic       hreadyout_q;
  logic       hresp_q;

  // Data-phase bookkeeping for the transfer currently owning the data bus
  logic             dp_vld_q, dp_vld_d;
  logic             dp_write_q, dp_write_d;
  logic [IDX_W-1:0] dp_idx_q;
  logic [BE_W-1:0]  dp_be_q;

  // Storage and read/forwarding path
  logic [HDATA_SIZE-1:0] mem_q [WORDS];
  logic [HDATA_SIZE-1:0] rd_q;
  logic                  fwd_vld_q;
  logic [HDATA_SIZE-1:0] fwd_data_q;
  logic [BE_W-1:0]       fwd_be_q;

  // Address-phase decode
  logic             acc;
  logic             acc_ok;
  logic             illegal;
  logic             priv_err;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             wr_now;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             fwd_hit;
  logic             unused_ok;

  assign addr_idx = HADDR[AW-1:WSH];

  generate
    if (BE_W > 1) begin : g_off
      assign addr_off = HADDR[OFF_W-1:0];
    end else begin : g_off0
      assign addr_off = '0;
    end
  endgenerate

`ifdef AHB3LITE_SRAM_PRIV_EN
  assign priv_err = ~HPROT[1];
`else
  assign priv_err = 1'b0;
`endif

  // Only the transfer-type MSB matters (NONSEQ/SEQ); burst and most
  // protection bits carry no meaning for a flat memory.
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  // A new address phase is only taken while this slave is not stalling.
  assign acc     = HSEL & HREADY & HTRANS[1] & hreadyout_q;
  assign illegal = is_illegal(HADDR, HSIZE) | priv_err;
  assign acc_ok  = acc & ~illegal;

  // The data phase of a legal write ends on the first edge with HREADYOUT=1.
  assign wr_now = dp_vld_q & dp_write_q & hreadyout_q;

  // Select when and from where the array is read; zero-wait reads use the
  // live address, waited reads use the latched one on the last wait cycle.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = addr_idx;
    if (WAIT_STATES == 0) begin
      rd_en  = acc_ok & ~HWRITE;
      rd_idx = addr_idx;
    end else begin
      rd_en  = (state_q == ST_WAIT) && (cnt_q == 4'd1) && dp_vld_q && !dp_write_q;
      rd_idx = dp_idx_q;
    end
  end

  // A read that samples the array on the same edge as a write to that word
  // would see stale contents, so the written lanes are overlaid afterwards.
  assign fwd_hit = wr_now && (dp_idx_q == rd_idx);

  // Next-state of data-phase control: updated whenever the bus advances.
  always_comb begin
    dp_vld_d   = dp_vld_q;
    dp_write_d = dp_write_q;
    if (hreadyout_q) begin
      dp_vld_d   = acc_ok;
      dp_write_d = acc_ok & HWRITE;
    end
  end

  // Transfer FSM with registered HREADYOUT/HRESP
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR2: begin
          if (acc && illegal) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else if (acc && (WAIT_STATES > 0)) begin
            state_q     <= ST_WAIT;
            cnt_q       <= WS_INIT;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b0;
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Data-phase control; reset drops any write that has not completed yet
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld_q   <= 1'b0;
      dp_write_q <= 1'b0;
    end else begin
      dp_vld_q   <= dp_vld_d;
      dp_write_q <= dp_write_d;
    end
  end

  // Latch word index and byte lanes of each accepted transfer
  always_ff @(posedge HCLK) begin
    if (acc) begin
      dp_idx_q <= addr_idx;
      dp_be_q  <= byte_en(HSIZE, addr_off);
    end
  end

  // Byte-lane writes at the end of a write data phase
  always_ff @(posedge HCLK) begin
    if (wr_now) begin
      for (int b = 0; b < BE_W; b++) begin
        if (dp_be_q[b]) begin
          mem_q[dp_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Synchronous array read; read data holds between reads
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_q      <= '0;
      fwd_vld_q <= 1'b0;
    end else if (rd_en) begin
      rd_q      <= mem_q[rd_idx];
      fwd_vld_q <= fwd_hit;
    end
  end

  // Capture the lanes being written alongside a forwarded read
  always_ff @(posedge HCLK) begin
    if (rd_en) begin
      fwd_data_q <= HWDATA;
      fwd_be_q   <= dp_be_q;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hresp_q ? '0
                   : merge_bytes(rd_q, fwd_data_q, fwd_vld_q ? fwd_be_q : '0);

endmodule

// File: doc/ahb3lite_sram_ws.md
Name: ahb3lite_sram_ws

Overview:
AHB3-Lite slave SRAM, successor to the zero-wait single-port SRAM.
- Adds a parametrised wait-state count per access.
- Adds a two-cycle ERROR response for out-of-range, misaligned and oversize transfers.
- Adds write-to-read forwarding for back-to-back accesses to the same word.
- Sits on the AHB3-Lite matrix as a generic on-chip data/instruction memory; the storage array is inferred inside the block.

Parameters:
- MEM_BYTES, 1024: memory size in bytes; must be a power of 2 and a multiple of HDATA_SIZE/8.
- HADDR_SIZE, 32: address bus width.
- HDATA_SIZE, 32: data bus width; one of 8, 16, 32, 64.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per valid transfer; range 0..15.

Ports:
- HCLK  in  1  clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  address
- HWDATA  in  HDATA_SIZE  write data, valid in data phase
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type; ignored except for pass-through
- HPROT  in  4  protection
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HREADY  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

Reset and clocking: reset HRESETn, asynchronous, active-low; clock HCLK.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, forwarding valid=0. Memory contents are not reset.
- Transfer accept: HSEL & HREADY & HTRANS in {NONSEQ, SEQ}. On accept, latch address, size, write and byte-enables. Byte-enables are HSIZE bytes shifted by the address offset within the word.
- IDLE/BUSY, or HSEL=0 with HREADY=1: zero-wait OKAY, no memory access.
- Error check at accept. A transfer is illegal if any of these hold:
  - HADDR >= MEM_BYTES;
  - HADDR is not aligned to HSIZE;
  - (8<<HSIZE) > HDATA_SIZE.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, HREADYOUT=1, HRESP=0. Illegal accept -> ERR1. Legal accept with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES. Legal accept with WAIT_STATES=0 -> stay IDLE; the data phase completes next cycle.
  - WAIT, HREADYOUT=0, HRESP=0. Counter decrements each cycle; at counter==1 -> IDLE. The data phase therefore completes after exactly WAIT_STATES low cycles.
  - ERR1, HREADYOUT=0, HRESP=1 -> ERR2 unconditionally.
  - ERR2, HREADYOUT=1, HRESP=1. The master may drive a new address here. Accept is evaluated as in IDLE, so ERR2 can go to IDLE, WAIT or ERR1.
- Writes: memory bytes are updated, per byte-enable, on the rising edge ending the data phase (the HREADYOUT=1 cycle). HWDATA is sampled on that edge. An erroring transfer never writes.
- Reads: the array has a 1-cycle synchronous read.
  - WAIT_STATES=0: the array is read with the address-phase HADDR, and HRDATA is valid in the next cycle.
  - WAIT_STATES>0: the array is read from the latched address; HRDATA is valid when HREADYOUT=1.
  - HRDATA holds its last value on non-read cycles.
- Forwarding: if a read's word address equals the word address written in the immediately preceding data phase, HRDATA = old word merged with the written bytes. Stale data is never returned.
- HRDATA is not checked during ERROR cycles; it is driven with 0.
- Reset mid-transfer: FSM returns to IDLE, HREADYOUT=1 immediately (asynchronously), and any pending write is dropped.

Optional Feature:
Macro AHB3LITE_SRAM_PRIV_EN.
- Defined: any accepted transfer with HPROT[1]=0 (user access) is treated as illegal and takes the ERR1/ERR2 path; no write and no read data.
- Undefined: HPROT is ignored entirely.

Test Plan:
1. WAIT_STATES=0, write NONSEQ WORD 0x10 = 0xDEADBEEF, then read 0x10 back-to-back -> write OKAY with zero waits; read returns 0xDEADBEEF via forwarding, with no HREADYOUT low.
2. WAIT_STATES=3, read 0x20 preloaded with 0x12345678 -> HREADYOUT low for exactly 3 cycles, then HREADYOUT=1, HRESP=0, HRDATA=0x12345678.
3. Read at HADDR=MEM_BYTES (0x400) -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); a write to 0x400 also leaves memory word 0 unchanged.
4. Byte write 0xAB to 0x13, then WORD read 0x10 previously 0x11223344 -> returns 0xAB223344; halfword write to 0x11 (misaligned) -> ERROR, word unchanged.
5. INCR4 burst with a BUSY inserted between beats 2 and 3, WAIT_STATES=1 -> BUSY gets a zero-wait OKAY; each of the 4 beats sees 1 wait cycle; data correct at 0x40..0x4C.
6. Assert HRESETn low while in WAIT (WAIT_STATES=5, cycle 2) -> HREADYOUT=1 and HRESP=0 immediately, pending write not performed. With AHB3LITE_SRAM_PRIV_EN defined, a read with HPROT=4'b0001 -> two-cycle ERROR.
